// File: rtl/pipeline_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshakes on both sides, flush, and a stall counter.
// SKID_EN=1 adds a second (skid) entry so that in_ready comes straight from a flop.
module pipeline_stage_skid #(
  parameter int DATA_W  = 64,
  parameter int CTRL_W  = 8,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]  stall_q;
  logic              accept;
  logic              emit;

  // An offer made in a flush cycle is never taken, whatever in_ready reads.
  assign accept = in_valid & in_ready & ~flush;
  assign emit   = out_valid & out_ready;

  // State and entry registers.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: the entry registers are reset to zero as well, so a freshly reset stage already holds a NOP bubble.
    if (!nRST) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      occ_q       <= 2'd0;
    end else begin
      // NOTE: Every sequential assignment is non-blocking, so all of these flops sample the values from before the edge.
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      occ_q       <= occ_d;
    end
  end

  // Next-state and datapath steering.
  always_comb begin
    // NOTE: each signal receives a default first, so no path through the case leaves a latch.
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      ONE: begin
        if (accept && emit) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (accept) begin
          state_d     = TWO;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
        end else if (emit) begin
          state_d     = EMPTY;
          main_data_d = '0;
          main_ctrl_d = '0;
        end
      end
      TWO: begin
        if (emit) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          skid_data_d = '0;
          skid_ctrl_d = '0;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // A flush wins over accept and emit. It leaves a zeroed, empty stage.
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = '0;
      main_ctrl_d = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end
  end

  always_comb begin
    occ_d = 2'd0;
    unique case (state_d)
      EMPTY:   occ_d = 2'd0;
      ONE:     occ_d = 2'd1;
      TWO:     occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  // Outputs. Data and control read as zero whenever no word is presented.
  always_comb begin
    out_valid = (state_q != EMPTY);
    out_data  = out_valid ? main_data_q : '0;
    out_ctrl  = out_valid ? main_ctrl_q : '0;
    occupancy = occ_q;
    stall_cnt = stall_q;
  end

  // Saturating count of back-pressured cycles. A flush does not clear it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      logic ready_q;

      // The flop holds "skid will be free". It depends on out_ready only through the state.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_d != TWO);
        end
      end

      assign in_ready = ready_q;
    end else begin : g_single
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Bench for pipeline_stage_skid: three instances (skid, single-entry, 4-bit counter) share one stimulus.
// A queue-style reference model checks them, together with directed expectations for the key scenarios.
module tb_pipeline_stage_skid;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             in_valid;
  logic [31:0]      in_data;
  logic [7:0]       in_ctrl;
  logic             out_ready;
  logic             flush;

  logic [2:0]       ir;
  logic [2:0]       ov;
  logic [2:0][31:0] od;
  logic [2:0][7:0]  oc;
  logic [2:0][1:0]  oo;
  logic [15:0]      sc0, sc1;
  logic [3:0]       sc2;

  int tests = 0;
  int fails = 0;

  // Reference model: each instance holds a list of up to two words ({ctrl,data}) and a stall count.
  logic [39:0] mw [3][2];
  int          mn [3];
  int          ms [3];
  bit          skid_m [3];
  int          smax [3];

  always #5 CLK = ~CLK;

  pipeline_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID_EN(1'b1), .CNT_W(16)) u_skid (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_ctrl(oc[0]), .flush(flush), .occupancy(oo[0]), .stall_cnt(sc0)
  );

  pipeline_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID_EN(1'b0), .CNT_W(16)) u_single (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_ctrl(oc[1]), .flush(flush), .occupancy(oo[1]), .stall_cnt(sc1)
  );

  pipeline_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID_EN(1'b1), .CNT_W(4)) u_sat (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .out_ctrl(oc[2]), .flush(flush), .occupancy(oo[2]), .stall_cnt(sc2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sc_of(input int i);
    case (i)
      0:       return sc0;
      1:       return sc1;
      default: return {12'd0, sc2};
    endcase
  endfunction

  function automatic bit m_rdy(input int i);
    if (skid_m[i]) return mn[i] < 2;
    return (mn[i] == 0) || out_ready;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mn[i] = 0;
      ms[i] = 0;
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit r, input bit f);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = 8'($urandom);
    out_ready = r;
    flush     = f;
  endtask

  // One clock cycle. Compare every output with the model at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit acc [3];
    bit em  [3];
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.in_ready", i), 64'(ir[i]), 64'(m_rdy(i)));
      check($sformatf("u%0d.out_valid", i), 64'(ov[i]), 64'(mn[i] > 0));
      check($sformatf("u%0d.out_data", i), 64'(od[i]), (mn[i] > 0) ? 64'(mw[i][0][31:0]) : 64'd0);
      check($sformatf("u%0d.out_ctrl", i), 64'(oc[i]), (mn[i] > 0) ? 64'(mw[i][0][39:32]) : 64'd0);
      check($sformatf("u%0d.occupancy", i), 64'(oo[i]), 64'(mn[i]));
      check($sformatf("u%0d.stall_cnt", i), 64'(sc_of(i)), 64'(ms[i]));
      acc[i] = in_valid && m_rdy(i) && !flush;
      em[i]  = (mn[i] > 0) && out_ready;
    end
    @(posedge CLK);
    for (int i = 0; i < 3; i++) begin
      if ((mn[i] > 0) && !out_ready && (ms[i] < smax[i])) ms[i]++;
      if (flush) begin
        mn[i] = 0;
      end else begin
        if (em[i]) begin
          mw[i][0] = mw[i][1];
          mn[i]--;
        end
        if (acc[i]) begin
          mw[i][mn[i]] = {in_ctrl, in_data};
          mn[i]++;
        end
      end
    end
    #1;
  endtask

  initial begin
    skid_m = '{1'b1, 1'b0, 1'b1};
    smax   = '{65535, 65535, 15};
    model_reset();
    nRST = 1'b0;
    drive(0, 32'd0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst.u%0d.in_ready", i), 64'(ir[i]), 64'd1);
      check($sformatf("rst.u%0d.out_valid", i), 64'(ov[i]), 64'd0);
      check($sformatf("rst.u%0d.out_data", i), 64'(od[i]), 64'd0);
      check($sformatf("rst.u%0d.occupancy", i), 64'(oo[i]), 64'd0);
      check($sformatf("rst.u%0d.stall_cnt", i), 64'(sc_of(i)), 64'd0);
    end
    nRST = 1'b1;

    // Stream 1..8 at full rate. Each word appears on the cycle after it is accepted.
    for (int i = 1; i <= 8; i++) begin
      drive(1, 32'(i), 1, 0);
      cycle();
      check("t1.data", 64'(od[0]), 64'(i));
      check("t1.occ", 64'(oo[0]), 64'd1);
      check("t1.stall", 64'(sc0), 64'd0);
    end
    drive(0, 32'd0, 1, 0);
    cycle();
    check("t1.drained", 64'(ov[0]), 64'd0);

    // A is held, and B goes into the skid entry.
    drive(1, 32'hA, 1, 0);
    cycle();
    check("t2.a_out", 64'(od[0]), 64'hA);
    drive(1, 32'hB, 0, 0);
    cycle();
    check("t2.occ2", 64'(oo[0]), 64'd2);
    check("t2.in_ready0", 64'(ir[0]), 64'd0);
    check("t2.a_still", 64'(od[0]), 64'hA);

    // Five more stalled cycles, then C is offered to a full stage.
    repeat (5) begin
      drive(0, 32'd0, 0, 0);
      cycle();
    end
    drive(1, 32'hC, 0, 0);
    cycle();
    check("t3.stall", 64'(sc0), 64'd7);
    check("t3.occ", 64'(oo[0]), 64'd2);
    check("t3.a_kept", 64'(od[0]), 64'hA);
    drive(0, 32'd0, 1, 0);
    cycle();
    check("t2.b_out", 64'(od[0]), 64'hB);
    check("t2.in_ready1", 64'(ir[0]), 64'd1);
    cycle();
    check("t2.empty", 64'(ov[0]), 64'd0);

    // Fill to two words, then flush while D is offered.
    drive(1, 32'h10, 0, 0);
    cycle();
    drive(1, 32'h11, 0, 0);
    cycle();
    check("t4.occ2", 64'(oo[0]), 64'd2);
    drive(1, 32'hD, 0, 1);
    cycle();
    check("t4.valid", 64'(ov[0]), 64'd0);
    check("t4.ctrl", 64'(oc[0]), 64'd0);
    check("t4.data", 64'(od[0]), 64'd0);
    check("t4.occ", 64'(oo[0]), 64'd0);
    check("t4.in_ready", 64'(ir[0]), 64'd1);
    drive(0, 32'd0, 1, 0);
    repeat (2) begin
      cycle();
      check("t4.no_d", 64'(ov[0]), 64'd0);
    end

    // Stall for 20 cycles. The 4-bit counter saturates, and a flush leaves the count alone.
    drive(1, 32'h30, 0, 0);
    cycle();
    repeat (20) begin
      drive(0, 32'd0, 0, 0);
      cycle();
    end
    check("t5.stall16", 64'(sc0), 64'd29);
    check("t5.sat", 64'({12'd0, sc2}), 64'd15);
    drive(0, 32'd0, 0, 1);
    cycle();
    check("t5.stall16_flush", 64'(sc0), 64'd30);
    check("t5.sat_flush", 64'({12'd0, sc2}), 64'd15);
    check("t5.occ", 64'(oo[2]), 64'd0);

    // The single-entry variant has a combinational in_ready and moves words back to back.
    drive(1, 32'h20, 1, 0);
    cycle();
    check("t6.first", 64'(od[1]), 64'h20);
    drive(1, 32'h21, 0, 0);
    #1;
    check("t6.rdy_low", 64'(ir[1]), 64'd0);
    out_ready = 1'b1;
    #1;
    check("t6.rdy_high", 64'(ir[1]), 64'd1);
    cycle();
    check("t6.second", 64'(od[1]), 64'h21);
    check("t6.occ", 64'(oo[1]), 64'd1);
    drive(1, 32'h22, 1, 0);
    cycle();
    check("t6.third", 64'(od[1]), 64'h22);
    drive(0, 32'd0, 1, 0);
    cycle();
    check("t6.drained", 64'(ov[1]), 64'd0);

    // Random traffic, with an asynchronous reset applied mid-stream.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        nRST = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
          check($sformatf("mid_rst.u%0d.valid", i), 64'(ov[i]), 64'd0);
          check($sformatf("mid_rst.u%0d.occ", i), 64'(oo[i]), 64'd0);
          check($sformatf("mid_rst.u%0d.ready", i), 64'(ir[i]), 64'd1);
        end
        check("mid_rst.stall", 64'(sc0), 64'd0);
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
      end
      drive(($urandom % 4) != 0, $urandom, (n % 64 < 12) ? 1'b0 : (($urandom % 3) != 0),
            ($urandom % 24) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
